// File: rtl/ram_access_arbiter.sv
// Single-port RAM arbiter between instruction fetch and MEM-stage data access.
// Each access takes one SERVE cycle, where the RAM port is driven from registers,
// followed by one RESP cycle carrying the registered ack. Data wins simultaneous
// requests, and a pending fetch is granted straight out of RESP_MEM so it cannot
// starve. The same holds in the other direction.
module ram_access_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_ack_o,
  output logic [DATA_WIDTH-1:0] if_data_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [3:0]            mem_sel_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  mem_ack_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  stallreq_o,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [3:0]            ram_sel_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i
);

  typedef enum logic [2:0] {
    StIdle,
    StServeMem,
    StServeIf,
    StRespMem,
    StRespIf
  } state_e;

  state_e                state_q;
  logic                  ram_ce_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [3:0]            ram_sel_q;
  logic [DATA_WIDTH-1:0] ram_data_q;
  logic                  if_ack_q;
  logic                  mem_ack_q;
  logic [DATA_WIDTH-1:0] if_data_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic                  grant_mem;
  logic                  grant_if;

  // Grant decision: the requester acked in a RESP cycle is not eligible in that cycle.
  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if ((state_q == StIdle) || (state_q == StRespIf)) begin
      grant_mem = mem_req_i;
    end
    if (!grant_mem && ((state_q == StIdle) || (state_q == StRespMem))) begin
      grant_if = if_req_i;
    end
  end

  // Arbitration FSM with registered RAM port, acks and read-data holding registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      ram_ce_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_sel_q  <= '0;
      ram_data_q <= '0;
      if_ack_q   <= 1'b0;
      mem_ack_q  <= 1'b0;
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else begin
      // The port is only driven during SERVE; acks only during RESP.
      ram_ce_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_sel_q  <= '0;
      ram_data_q <= '0;
      if_ack_q   <= 1'b0;
      mem_ack_q  <= 1'b0;

      unique case (state_q)
        StServeMem: begin
          if (!ram_we_q) begin
            mem_data_q <= ram_data_i;
          end
          mem_ack_q <= 1'b1;
          state_q   <= StRespMem;
        end
        StServeIf: begin
          if_data_q <= ram_data_i;
          if_ack_q  <= 1'b1;
          state_q   <= StRespIf;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      // A grant overrides the defaults above; it is only possible in IDLE or RESP.
      if (grant_mem) begin
        ram_ce_q   <= 1'b1;
        ram_we_q   <= mem_we_i;
        ram_addr_q <= mem_addr_i;
        ram_sel_q  <= mem_sel_i;
        ram_data_q <= mem_data_i;
        state_q    <= StServeMem;
      end else if (grant_if) begin
        ram_ce_q   <= 1'b1;
        ram_we_q   <= 1'b0;
        ram_addr_q <= if_addr_i;
        ram_sel_q  <= 4'b1111;
        ram_data_q <= '0;
        state_q    <= StServeIf;
      end
    end
  end

  assign ram_ce_o   = ram_ce_q;
  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_sel_o  = ram_sel_q;
  assign ram_data_o = ram_data_q;
  assign if_ack_o   = if_ack_q;
  assign mem_ack_o  = mem_ack_q;
  assign if_data_o  = if_data_q;
  assign mem_data_o = mem_data_q;

  assign stallreq_o = (if_req_i & ~if_ack_q) | (mem_req_i & ~mem_ack_q);

endmodule
